// File: rtl/serial_in_pkg.sv
// Shared constants for the serial receive/transmit pair.
//   - FSM state encodings for serial_in
//   - repeat-mode constants shared with the serial output block
package serial_in_pkg;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RECV = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic ONE_SHOT = 1'b0;
  localparam logic REPEAT   = 1'b1;

  localparam int TICK_CNT_W = 8;
endpackage

// File: rtl/serial_in_sync_2ff.sv
// Generic 2-flop synchroniser for asynchronous pad inputs.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset (flops clear to 0)
//   d     - asynchronous input
//   q     - synchronised output, 2 clocks of latency
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/serial_in.sv
// Serial receiver: samples an idle-low, LSB-first, unframed serial line at
// mid-bit using tick-based bit timing and reassembles DATA_BIT-bit words.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   i_tick       - bit-timing tick (TICK_PER_BIT ticks per bit)
//   i_start      - begin receiving; this clock starts bit 0
//   i_stop       - abort reception (partial word discarded)
//   i_mode       - ONE_SHOT / REPEAT (back-to-back words)
//   i_serial     - serial line, asynchronous to clk
//   o_data       - last completed word
//   o_bit_tick   - one-clock pulse at the end of each received bit
//   o_busy       - high while receiving or presenting a word
//   o_done_tick  - one-clock pulse when o_data updates
module serial_in
  import serial_in_pkg::*;
#(
  parameter int DATA_BIT     = 16,
  parameter int TICK_PER_BIT = 16,
  parameter int SAMPLE_TICK  = TICK_PER_BIT / 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_tick,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_mode,
  input  logic                i_serial,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_bit_tick,
  output logic                o_busy,
  output logic                o_done_tick
);
  localparam int BIDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam logic [TICK_CNT_W-1:0] CNT_SAMPLE = TICK_CNT_W'(SAMPLE_TICK);
  localparam logic [TICK_CNT_W-1:0] CNT_LAST   = TICK_CNT_W'(TICK_PER_BIT - 1);
  localparam logic [BIDX_W-1:0]     BIDX_LAST  = BIDX_W'(DATA_BIT - 1);

  logic                  sbit;
  logic [1:0]            state, state_n;
  logic [TICK_CNT_W-1:0] cnt, cnt_n;
  logic [BIDX_W-1:0]     bidx, bidx_n;
  logic [DATA_BIT-1:0]   shift, shift_n;
  logic [DATA_BIT-1:0]   data_n;
  logic                  bt_n, dt_n;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_serial),
    .q     (sbit)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bidx_n  = bidx;
    shift_n = shift;
    data_n  = o_data;
    bt_n    = 1'b0;
    dt_n    = 1'b0;
    case (state)
      S_RECV: begin
        if (i_stop) begin
          state_n = S_IDLE;
        end else if (i_tick) begin
          // Single mid-bit sample; line activity on other ticks is ignored.
          if (cnt == CNT_SAMPLE)
            shift_n = {sbit, shift[DATA_BIT-1:1]};
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            bt_n  = 1'b1;
            if (bidx == BIDX_LAST) state_n = S_DONE;
            else                   bidx_n  = bidx + 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        // Done pulse is unconditional; i_stop only cancels the repeat.
        data_n = shift;
        dt_n   = 1'b1;
        if (i_mode == REPEAT && !i_stop) begin
          cnt_n   = '0;
          bidx_n  = '0;
          state_n = S_RECV;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: begin
        // S_IDLE and any illegal encoding
        state_n = S_IDLE;
        if (i_start) begin
          cnt_n   = '0;
          bidx_n  = '0;
          state_n = S_RECV;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bidx        <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_bit_tick  <= 1'b0;
      o_done_tick <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bidx        <= bidx_n;
      shift       <= shift_n;
      o_data      <= data_n;
      o_bit_tick  <= bt_n;
      o_done_tick <= dt_n;
    end
  end

  assign o_busy = (state == S_RECV) || (state == S_DONE);
endmodule

// File: tb/tb_serial_in.sv
module tb_serial_in;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_tick = 1'b1;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_mode = 1'b0;
  logic        i_serial = 1'b0;
  logic [15:0] o_data;
  logic        o_bit_tick, o_busy, o_done_tick;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int          done_cyc[$];
  logic [15:0] done_dat[$];
  int          bt_cyc[$];

  typedef struct {
    logic [15:0] data;
    bit          glitch;
  } vec_t;
  vec_t vecs[4];

  serial_in #(.DATA_BIT(16), .TICK_PER_BIT(16), .SAMPLE_TICK(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_start(i_start),
    .i_stop(i_stop), .i_mode(i_mode), .i_serial(i_serial),
    .o_data(o_data), .o_bit_tick(o_bit_tick), .o_busy(o_busy),
    .o_done_tick(o_done_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_done_tick) begin
      done_cyc.push_back(cyc);
      done_dat.push_back(o_data);
    end
    if (o_bit_tick) bt_cyc.push_back(cyc);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    done_cyc.delete();
    done_dat.delete();
    bt_cyc.delete();
  endtask

  // Behavioural transmitter, one tick per clock: bit k is placed on the line
  // for the 16 clocks of receiver bit k; optional 1-clock glitches at ticks 2/13.
  task automatic send(input logic [15:0] d, input int nbits, input bit glitch, input bit do_start);
    if (do_start) begin
      @(posedge clk); #1 i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
    end
    for (int k = 0; k < nbits; k++)
      for (int j = 0; j < 16; j++) begin
        i_serial = (glitch && (j == 2 || j == 13)) ? ~d[k] : d[k];
        @(posedge clk); #1;
      end
    i_serial = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 1'b0};
    vecs[1] = '{16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 1'b0};
    vecs[3] = '{16'h3C96, 1'b0};

    // Reset state
    #12;
    chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_bt", o_bit_tick, 0);
    chk("rst_done", o_done_tick, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_clk(2);

    // Abort after bit 7
    clr();
    send(16'h00FF, 8, 1'b0, 1'b1);
    i_stop = 1'b1;
    wait_clk(1);
    i_stop = 1'b0;
    wait_clk(300);
    chk("abort_ndone", done_cyc.size(), 0);
    chk("abort_data", o_data, 0);
    chk("abort_busy", o_busy, 0);
    clr();
    send(16'h8001, 16, 1'b0, 1'b1);
    wait_clk(4);
    chk("after_abort_ndone", done_cyc.size(), 1);
    chk("after_abort_data", o_data, 16'h8001);

    // Table-driven one-shot words
    foreach (vecs[i]) begin
      clr();
      send(vecs[i].data, 16, vecs[i].glitch, 1'b1);
      wait_clk(4);
      chk("vec_ndone", done_cyc.size(), 1);
      if (done_dat.size() > 0) chk("vec_done_data", done_dat[0], vecs[i].data);
      chk("vec_data", o_data, vecs[i].data);
      chk("vec_busy", o_busy, 0);
      if (i == 0) begin
        chk("bt_count", bt_cyc.size(), 16);
        for (int b = 1; b < bt_cyc.size(); b++)
          chk("bt_spacing", bt_cyc[b] - bt_cyc[b-1], 16);
      end
    end

    // Repeat mode: two words with the 1-clock gap
    clr();
    i_mode = 1'b1;
    send(16'h1234, 16, 1'b0, 1'b1);
    wait_clk(1);
    i_mode = 1'b0;
    send(16'hFFFF, 16, 1'b0, 1'b0);
    wait_clk(4);
    chk("rep_ndone", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      chk("rep_gap", done_cyc[1] - done_cyc[0], 257);
      chk("rep_d0", done_dat[0], 16'h1234);
      chk("rep_d1", done_dat[1], 16'hFFFF);
    end
    chk("rep_busy", o_busy, 0);

    // Reset mid-word (during bit 5)
    clr();
    send(16'h5A5A, 5, 1'b0, 1'b1);
    i_serial = 1'b1;
    wait_clk(7);
    chk("pre_rst_busy", o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_bt", o_bit_tick, 0);
    chk("mid_rst_done", o_done_tick, 0);
    i_serial = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    wait_clk(3);
    chk("mid_rst_ndone", done_cyc.size(), 0);
    clr();
    send(16'h5A5A, 16, 1'b0, 1'b1);
    wait_clk(4);
    chk("post_rst_ndone", done_cyc.size(), 1);
    chk("post_rst_data", o_data, 16'h5A5A);

    // Loopback against a behavioural transmitter, tick divided by 4
    clr();
    i_tick = 1'b0;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 64; j++) begin
        i_serial = logic'(16'hC0DE >> k);
        i_tick = ((j % 4) == 3);
        @(posedge clk); #1;
      end
    i_serial = 1'b0;
    i_tick = 1'b1;
    wait_clk(4);
    chk("lb_ndone", done_cyc.size(), 1);
    chk("lb_data", o_data, 16'hC0DE);
    chk("lb_busy", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_in.md
Name: serial_in

Overview:
- Receive-side counterpart of the team's serial output block.
- Samples a single-wire, LSB-first, unframed serial stream (idle low, no start/stop bits) at mid-bit, using the same tick-based bit timing as the transmitter.
- Reassembles DATA_BIT-bit words and presents each completed word with a one-clock done strobe.
- Sits at the board input, typically in loopback against the serial output block for self-test.

Parameters:
- DATA_BIT, 16, bits per word (2..32).
- TICK_PER_BIT, 16, i_tick pulses per bit period (2..256).
- SAMPLE_TICK, TICK_PER_BIT/2, tick index within a bit at which the line is sampled; must be < TICK_PER_BIT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_tick  in  1  bit-timing tick; same source and rate as the transmitter
- i_start  in  1  begin receiving; the current clock is the start of bit 0
- i_stop  in  1  abort reception
- i_mode  in  1  0 = one-shot, 1 = repeat (back-to-back words)
- i_serial  in  1  serial line, asynchronous to clk
- o_data  out  DATA_BIT  last completed word
- o_bit_tick  out  1  one-clock pulse at the end of each received bit
- o_busy  out  1  high in S_RECV and S_DONE
- o_done_tick  out  1  one-clock pulse when o_data updates

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: all outputs 0; internal state S_IDLE; counters 0; shift register 0; synchroniser 0.
- Synchroniser:
  - i_serial passes through a 2-flop synchroniser, adding 2 clocks of latency.
  - Controllers align i_start so that the skew between the synchronised line and the receiver bit window is under SAMPLE_TICK ticks.
- S_IDLE:
  - Shift register and counters are held.
  - On i_start: tick count = 0, bit index = 0, go to S_RECV.
- S_RECV:
  - i_stop has priority over everything: go to S_IDLE, no done pulse, o_data unchanged, partial word discarded.
  - Otherwise, on i_tick with count == SAMPLE_TICK: shift = {synced_bit, shift[DATA_BIT-1:1]}. Bits arrive LSB first, so after DATA_BIT samples bit 0 sits at shift[0].
  - On i_tick with count == TICK_PER_BIT-1:
    - count = 0 and o_bit_tick = 1 on the next clock.
    - If bit index == DATA_BIT-1, go to S_DONE; otherwise increment the bit index.
  - Any other i_tick increments count. No i_tick means no change.
  - i_start in S_RECV is ignored.
- S_DONE (exactly one clock):
  - o_data <= shift and o_done_tick <= 1, both visible on the same cycle after the edge.
  - If i_mode == 1 and i_stop == 0: count = 0, bit index = 0, go to S_RECV. This matches the transmitter's one-clock gap between words.
  - Otherwise go to S_IDLE.
  - i_stop in S_DONE suppresses the repeat but not the done pulse.
- Widths:
  - Tick counter is 8 bits.
  - Bit index is $clog2(DATA_BIT) bits, minimum 1.
  - No wrap of either counter occurs within legal parameters.
- Glitch handling: changes on the line away from the sample tick have no effect. Only one sample per bit is taken.
- Illegal state: encoding decodes to S_IDLE.
- Reset mid-word: immediate return to reset values; no done pulse.

Decomposition:
- Shared package/include holds:
  - state encodings S_IDLE = 2'b00, S_RECV = 2'b01, S_DONE = 2'b10;
  - mode constants ONE_SHOT = 1'b0, REPEAT = 1'b1, shared with the serial output block.
- One natural sub-module, sync_2ff: a generic 2-flop synchroniser with async active-low reset, reusable for other pad inputs.
- Everything else is a single FSMD with a register block plus a next-state block.

Test Plan:
All cases use DATA_BIT=16, TICK_PER_BIT=16, SAMPLE_TICK=8, i_tick=1 every clock, driven by a behavioural transmitter aligned per the synchroniser latency.
1. One-shot word:
   - Stimulus: send 16'hA5C3.
   - Required: o_bit_tick pulses 16 times, 16 clocks apart.
   - Required: o_done_tick is one clock wide, o_data = 16'hA5C3, FSM returns to S_IDLE, o_busy low afterwards.
2. Repeat mode:
   - Stimulus: send 16'h1234 then 16'hFFFF back-to-back with the 1-clock transmitter gap.
   - Required: two done pulses, 257 clocks apart; o_data = 16'h1234, then 16'hFFFF.
3. Abort:
   - Stimulus: assert i_stop after bit 7 of 16'h00FF.
   - Required: no done pulse; o_data keeps its previous value (0 after reset); S_IDLE.
   - Follow-up: a new i_start then receives 16'h8001 correctly.
4. Glitch immunity:
   - Stimulus: inject 1-clock pulses on i_serial at ticks 2 and 13 of every bit while sending 16'h0000.
   - Required: o_data = 16'h0000.
5. Reset mid-word:
   - Stimulus: drop rst_n during bit 5.
   - Required: all outputs 0 asynchronously; after release, 16'h5A5A is received correctly.
6. Loopback:
   - Stimulus: connect the serial output block to this block, shared i_tick divided by 4, i_mode = 0, data 16'hC0DE.
   - Required: o_data = 16'hC0DE with exactly one done pulse.
